// File: rtl/sdram_refresh_sched.sv
// SDRAM init + periodic auto-refresh scheduler sharing the command bus with the access engine.
// Latency: all outputs registered; a command issues the cycle after its wait expires, grant the cycle after a request in IDLE.
// Backpressure: acc_req is held off during init/refresh; refresh ticks during an access accumulate as saturating debt.
module sdram_refresh_sched #(
  parameter int          T_INIT         = 20000,
  parameter int          T_RP           = 3,
  parameter int          T_RFC          = 7,
  parameter int          T_MRD          = 2,
  parameter int          INIT_REFRESHES = 8,
  parameter int          REF_INTERVAL   = 780,
  parameter int          MAX_DEBT       = 8,
  parameter logic [12:0] MODE_REG       = 13'h030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc_req,
  output logic        acc_gnt,
  output logic        sch_own,
  output logic [3:0]  sch_cmd,
  output logic [12:0] sch_addr,
  output logic [1:0]  sch_ba,
  output logic        sch_cke,
  output logic        init_done,
  output logic [3:0]  ref_pending,
  output logic        ref_overflow
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int WAIT_A   = (T_INIT > T_RP) ? T_INIT : T_RP;
  localparam int WAIT_B   = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int WAIT_MAX = (WAIT_A > WAIT_B) ? WAIT_A : WAIT_B;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int RC_W     = $clog2(INIT_REFRESHES + 1);
  localparam int TMR_W    = $clog2(REF_INTERVAL + 1);

  typedef enum logic [2:0] {
    INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE, ACCESS, REF_PRE, REF_AR
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [12:0]        addr_q, addr_d;
  logic [1:0]         ba_q, ba_d;
  logic               gnt_q, gnt_d;
  logic               own_q, own_d;
  logic               cke_q, cke_d;
  logic               done_q, done_d;
  logic [3:0]         pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               tick;
  logic               ar_issue;
  logic               cnt_zero;

  // Next-state, next-output, refresh timer and debt bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rc_d     = rc_q;
    tmr_d    = tmr_q;
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    ba_d     = '0;
    gnt_d    = 1'b0;
    own_d    = 1'b1;
    cke_d    = 1'b1;
    done_d   = done_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    tick     = 1'b0;
    ar_issue = 1'b0;
    cnt_zero = (cnt_q == '0);

    // Wait counter runs down in every state; a load below overrides it.
    if (!cnt_zero) cnt_d = cnt_q - 1'b1;

    // Free-running refresh timer, only alive once init has completed.
    if (done_q) begin
      if (tmr_q == TMR_W'(REF_INTERVAL - 1)) begin
        tmr_d = '0;
        tick  = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    case (state_q)
      INIT_WAIT: if (cnt_zero) begin
        cmd_d   = CMD_PRE;
        addr_d  = 13'h0400;
        cnt_d   = CNT_W'(T_RP - 1);
        state_d = INIT_PRE;
      end
      INIT_PRE: if (cnt_zero) begin
        cmd_d   = CMD_REF;
        cnt_d   = CNT_W'(T_RFC - 1);
        rc_d    = RC_W'(1);
        state_d = INIT_REF;
      end
      INIT_REF: if (cnt_zero) begin
        if (rc_q == RC_W'(INIT_REFRESHES)) begin
          cmd_d   = CMD_MRS;
          addr_d  = MODE_REG;
          cnt_d   = CNT_W'(T_MRD - 1);
          state_d = INIT_MRS;
        end else begin
          cmd_d = CMD_REF;
          cnt_d = CNT_W'(T_RFC - 1);
          rc_d  = rc_q + 1'b1;
        end
      end
      INIT_MRS: if (cnt_zero) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        // Owed refreshes always win over a pending access.
        if (pend_q != '0) begin
          cmd_d   = CMD_PRE;
          addr_d  = 13'h0400;
          cnt_d   = CNT_W'(T_RP - 1);
          state_d = REF_PRE;
        end else if (acc_req) begin
          gnt_d   = 1'b1;
          own_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (acc_req) begin
          gnt_d = 1'b1;
          own_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      REF_PRE: if (cnt_zero) begin
        cmd_d    = CMD_REF;
        ar_issue = 1'b1;
        cnt_d    = CNT_W'(T_RFC - 1);
        state_d  = REF_AR;
      end
      REF_AR: if (cnt_zero) state_d = IDLE;
      default: state_d = INIT_WAIT;
    endcase

    // Debt: tick adds, refresh issue removes, both together cancel out.
    if (tick && (pend_q == 4'(MAX_DEBT))) ovf_d = 1'b1;
    if (tick && !ar_issue && (pend_q != 4'(MAX_DEBT))) pend_d = pend_q + 1'b1;
    else if (ar_issue && !tick) pend_d = pend_q - 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT_WAIT;
      cnt_q   <= CNT_W'(T_INIT - 1);
      rc_q    <= '0;
      tmr_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      gnt_q   <= 1'b0;
      own_q   <= 1'b1;
      cke_q   <= 1'b1;
      done_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      tmr_q   <= tmr_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      cke_q   <= cke_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc_gnt      = gnt_q;
  assign sch_own      = own_q;
  assign sch_cmd      = cmd_q;
  assign sch_addr     = addr_q;
  assign sch_ba       = ba_q;
  assign sch_cke      = cke_q;
  assign init_done    = done_q;
  assign ref_pending  = pend_q;
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched with a cycle-stamped expectation scoreboard.
// Latency: expectations are keyed to the cycle number counted from reset release.
// Backpressure: acc_req is driven in directed steps; outputs sampled on the falling edge.
module tb_sdram_refresh_sched;

  localparam int S_CMD  = 0;
  localparam int S_ADDR = 1;
  localparam int S_BA   = 2;
  localparam int S_GNT  = 3;
  localparam int S_OWN  = 4;
  localparam int S_CKE  = 5;
  localparam int S_DONE = 6;
  localparam int S_PEND = 7;
  localparam int S_OVF  = 8;

  localparam logic [15:0] NOP = 16'h7;
  localparam logic [15:0] PRE = 16'h2;
  localparam logic [15:0] REF = 16'h1;
  localparam logic [15:0] MRS = 16'h0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        acc_req = 1'b0;
  logic        acc_gnt, sch_own, sch_cke, init_done, ref_overflow;
  logic [3:0]  sch_cmd, ref_pending;
  logic [12:0] sch_addr;
  logic [1:0]  sch_ba;

  exp_t  sb[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  string scen = "";

  sdram_refresh_sched #(
    .T_INIT(10), .T_RP(2), .T_RFC(7), .T_MRD(2),
    .INIT_REFRESHES(2), .REF_INTERVAL(50), .MAX_DEBT(3)
  ) dut (
    .clk(clk), .reset(reset), .acc_req(acc_req),
    .acc_gnt(acc_gnt), .sch_own(sch_own), .sch_cmd(sch_cmd),
    .sch_addr(sch_addr), .sch_ba(sch_ba), .sch_cke(sch_cke),
    .init_done(init_done), .ref_pending(ref_pending), .ref_overflow(ref_overflow)
  );

  always #5 clk = ~clk;

  function automatic string sig_name(input int s);
    case (s)
      S_CMD:   return "cmd";
      S_ADDR:  return "addr";
      S_BA:    return "ba";
      S_GNT:   return "gnt";
      S_OWN:   return "own";
      S_CKE:   return "cke";
      S_DONE:  return "done";
      S_PEND:  return "pend";
      default: return "ovf";
    endcase
  endfunction

  function automatic logic [15:0] observe(input int s);
    case (s)
      S_CMD:   return {12'b0, sch_cmd};
      S_ADDR:  return {3'b0, sch_addr};
      S_BA:    return {14'b0, sch_ba};
      S_GNT:   return {15'b0, acc_gnt};
      S_OWN:   return {15'b0, sch_own};
      S_CKE:   return {15'b0, sch_cke};
      S_DONE:  return {15'b0, init_done};
      S_PEND:  return {12'b0, ref_pending};
      default: return {15'b0, ref_overflow};
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    e.tag = $sformatf("%s_%s", scen, sig_name(s));
    sb.push_back(e);
  endtask

  task automatic expect_rst(input int c);
    expect_at(c, S_CMD, NOP);  expect_at(c, S_ADDR, 16'h0); expect_at(c, S_BA, 16'h0);
    expect_at(c, S_GNT, 16'h0); expect_at(c, S_OWN, 16'h1); expect_at(c, S_CKE, 16'h1);
    expect_at(c, S_DONE, 16'h0); expect_at(c, S_PEND, 16'h0); expect_at(c, S_OVF, 16'h0);
  endtask

  task automatic expect_init();
    expect_rst(0);
    for (int c = 1; c <= 9; c++) expect_at(c, S_CMD, NOP);
    for (int c = 0; c <= 28; c++) expect_at(c, S_GNT, 16'h0);
    expect_at(10, S_CMD, PRE);  expect_at(10, S_ADDR, 16'h0400);
    expect_at(11, S_CMD, NOP);  expect_at(11, S_ADDR, 16'h0);
    expect_at(12, S_CMD, REF);  expect_at(13, S_CMD, NOP);
    expect_at(18, S_CMD, NOP);  expect_at(19, S_CMD, REF);
    expect_at(25, S_CMD, NOP);
    expect_at(26, S_CMD, MRS);  expect_at(26, S_ADDR, 16'h0030); expect_at(26, S_BA, 16'h0);
    expect_at(27, S_CMD, NOP);  expect_at(27, S_ADDR, 16'h0);    expect_at(27, S_DONE, 16'h0);
    expect_at(28, S_DONE, 16'h1); expect_at(28, S_CMD, NOP);      expect_at(15, S_CKE, 16'h1);
  endtask

  task automatic check_now();
    logic [15:0] o;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        o = observe(sb[i].sig);
        checks++;
        assert (o === sb[i].val) else begin
          errors++;
          $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", sb[i].tag, cyc, o, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic start();
    acc_req = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cyc = 0;
    @(negedge clk);
    check_now();
  endtask

  task automatic end_scen();
    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL %s_unconsumed: observed=%0d expected=0", scen, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    // Init sequence, idle refresh, then reset during the refresh wait.
    scen = "init_idle";
    expect_init();
    expect_at(77, S_PEND, 16'h0); expect_at(78, S_PEND, 16'h1); expect_at(78, S_CMD, NOP);
    expect_at(79, S_CMD, PRE);    expect_at(79, S_ADDR, 16'h0400); expect_at(80, S_CMD, NOP);
    expect_at(81, S_CMD, REF);    expect_at(81, S_PEND, 16'h0);   expect_at(82, S_CMD, NOP);
    expect_at(81, S_OWN, 16'h1);
    expect_rst(84);
    start();
    run_to(83);
    reset = 1'b1;
    run_to(84);
    end_scen();

    // Init replay, long access accumulating debt, drain, re-arbitration.
    scen = "access";
    expect_init();
    expect_at(30, S_GNT, 16'h0);  expect_at(31, S_GNT, 16'h1);  expect_at(31, S_OWN, 16'h0);
    expect_at(100, S_CMD, NOP);   expect_at(78, S_PEND, 16'h1); expect_at(128, S_PEND, 16'h2);
    expect_at(177, S_PEND, 16'h2); expect_at(178, S_PEND, 16'h3);
    expect_at(200, S_GNT, 16'h1); expect_at(201, S_GNT, 16'h0); expect_at(201, S_OWN, 16'h1);
    expect_at(200, S_OVF, 16'h0);
    expect_at(202, S_CMD, PRE);   expect_at(202, S_ADDR, 16'h0400);
    expect_at(204, S_CMD, REF);   expect_at(204, S_PEND, 16'h2);
    expect_at(212, S_CMD, PRE);   expect_at(214, S_CMD, REF);   expect_at(214, S_PEND, 16'h1);
    expect_at(222, S_CMD, PRE);   expect_at(224, S_CMD, REF);   expect_at(224, S_PEND, 16'h0);
    expect_at(210, S_GNT, 16'h0); expect_at(220, S_GNT, 16'h0); expect_at(230, S_GNT, 16'h0);
    expect_at(228, S_PEND, 16'h1); expect_at(232, S_CMD, PRE);  expect_at(234, S_CMD, REF);
    expect_at(234, S_PEND, 16'h0); expect_at(241, S_GNT, 16'h0); expect_at(242, S_GNT, 16'h1);
    expect_at(242, S_OVF, 16'h0); expect_at(260, S_GNT, 16'h1); expect_at(261, S_GNT, 16'h0);
    expect_at(262, S_GNT, 16'h1); expect_at(271, S_GNT, 16'h0);
    start();
    run_to(30);  acc_req = 1'b1;
    run_to(200); acc_req = 1'b0;
    run_to(205); acc_req = 1'b1;
    run_to(260); acc_req = 1'b0;
    run_to(261); acc_req = 1'b1;
    run_to(270); acc_req = 1'b0;
    run_to(272);
    end_scen();

    // Debt overflow during a long access; flag survives the drain.
    scen = "overflow";
    expect_rst(0);
    expect_at(178, S_PEND, 16'h3); expect_at(227, S_OVF, 16'h0); expect_at(228, S_OVF, 16'h1);
    expect_at(228, S_PEND, 16'h3); expect_at(250, S_GNT, 16'h1); expect_at(251, S_GNT, 16'h0);
    expect_at(252, S_CMD, PRE);    expect_at(254, S_CMD, REF);   expect_at(254, S_PEND, 16'h2);
    expect_at(264, S_PEND, 16'h1); expect_at(274, S_PEND, 16'h0); expect_at(276, S_OVF, 16'h1);
    expect_at(278, S_PEND, 16'h1);
    start();
    run_to(30);  acc_req = 1'b1;
    run_to(250); acc_req = 1'b0;
    run_to(280);
    end_scen();

    // Refresh issue lands on a tick cycle: debt must not move.
    scen = "tick_dec";
    expect_rst(0);
    expect_at(128, S_PEND, 16'h2); expect_at(175, S_GNT, 16'h0); expect_at(176, S_CMD, PRE);
    expect_at(177, S_PEND, 16'h2); expect_at(178, S_CMD, REF);   expect_at(178, S_PEND, 16'h2);
    expect_at(186, S_CMD, PRE);    expect_at(188, S_PEND, 16'h1); expect_at(198, S_PEND, 16'h0);
    expect_at(198, S_OVF, 16'h0);
    start();
    run_to(30);  acc_req = 1'b1;
    run_to(174); acc_req = 1'b0;
    run_to(200);
    end_scen();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_refresh_sched.md
# sdram_refresh_sched

Init and refresh scheduler that sits beside `AxiSdramCtrl` in the single-port SDRAM subsystem, in the `soc_clk` domain. It owns the SDRAM command pins during power-up initialisation and periodic auto-refresh. It arbitrates the command bus with the access engine through a request/grant handshake. It tracks postponed refreshes as a bounded debt counter and flags a debt overflow.

## Interface
Parameters:
- `T_INIT`, 20000: NOP cycles after reset before the first command (200 µs at 100 MHz).
- `T_RP`, 3: cycles from PRECHARGE to the next command.
- `T_RFC`, 7: cycles from AUTO REFRESH to the next command.
- `T_MRD`, 2: cycles from LOAD MODE to `init_done`.
- `INIT_REFRESHES`, 8: number of AUTO REFRESH commands during init (≥1).
- `REF_INTERVAL`, 780: cycles per refresh tick (7.8 µs).
- `MAX_DEBT`, 8: saturation value of the pending-refresh counter.
- `MODE_REG`, 13'h030: value driven on `sch_addr` for LOAD MODE (CAS 3, BL 1).

Ports:
- `clk` in 1: SoC clock.
- `reset` in 1: synchronous, active-high.
- `acc_req` in 1: access engine requests the bus; held high for the whole transaction.
- `acc_gnt` out 1: access engine owns the SDRAM pins.
- `sch_own` out 1: scheduler owns the pins; equals `~acc_gnt`. The external mux selects `sch_*` when this is 1.
- `sch_cmd` out 4: {CSn, RASn, CASn, WEn}.
- `sch_addr` out 13: address bus.
- `sch_ba` out 2: bank address.
- `sch_cke` out 1: clock enable.
- `init_done` out 1: init complete; sticky until reset.
- `ref_pending` out 4: current refresh debt.
- `ref_overflow` out 1: sticky; set when a tick arrives with debt == `MAX_DEBT`.

## Operation
- Command encodings:
  - NOP = 4'b0111.
  - PRECHARGE ALL = 4'b0010 with `sch_addr` = 13'h0400 (A10 = 1).
  - AUTO REFRESH = 4'b0001.
  - LOAD MODE = 4'b0000 with `sch_addr` = `MODE_REG`, `sch_ba` = 0.
- Every command lasts exactly one cycle. NOP is driven in all other scheduler-owned cycles. `sch_addr` and `sch_ba` are 0 except where listed above.
- FSM states:
  - Init: INIT_WAIT → INIT_PRE → INIT_REF → INIT_MRS.
  - Run: IDLE, ACCESS, REF_PRE, REF_AR.
  - Wait: each command state has a down-counter wait; the next command issues exactly T_x cycles after the previous one.
- Init sequence:
  - NOP for `T_INIT` cycles.
  - PRECHARGE ALL, wait `T_RP`.
  - `INIT_REFRESHES` × (AUTO REFRESH, wait `T_RFC`).
  - LOAD MODE, wait `T_MRD`.
  - `init_done` = 1, enter IDLE.
- Refresh timer:
  - Free-running; starts counting on the cycle `init_done` rises.
  - Ticks every `REF_INTERVAL` cycles. A tick increments `ref_pending`, saturating at `MAX_DEBT`.
  - No ticks before `init_done`.
- IDLE priority:
  - If `ref_pending` ≠ 0, go to REF_PRE, then REF_AR.
  - Otherwise, if `acc_req`, go to ACCESS.
- Refresh sequence: PRECHARGE ALL, wait `T_RP`, AUTO REFRESH, wait `T_RFC`, return to IDLE. `ref_pending` decrements on the AUTO REFRESH issue cycle. A tick in the same cycle leaves it unchanged.
- ACCESS:
  - `acc_gnt` = 1 and scheduler drives NOP; its outputs are ignored.
  - A refresh tick never preempts an access; debt accumulates instead.
  - Leave to IDLE when `acc_req` is sampled low.
- Debt overflow: a tick with `ref_pending` == `MAX_DEBT` sets `ref_overflow`; the counter stays at `MAX_DEBT`.
- `acc_req` during init or refresh is held off; it is granted only from IDLE with zero debt.

## Timing
- Values during reset and on the first cycle after reset:
  - `sch_cmd` = NOP, `sch_cke` = 1, `sch_addr` = 0, `sch_ba` = 0.
  - `acc_gnt` = 0, `sch_own` = 1.
  - `init_done` = 0, `ref_pending` = 0, `ref_overflow` = 0.
  - State = INIT_WAIT; the timer is cleared.
- All outputs are registered.
- `acc_gnt` rises on the cycle after `acc_req` is sampled high in IDLE (debt 0). It falls on the cycle after `acc_req` is sampled low.
- Re-arbitration: the earliest re-grant after a release is 2 cycles after `acc_req` falls (one IDLE cycle).
- IDLE → REF_PRE: the PRECHARGE issues on the cycle after IDLE sees debt ≠ 0.
- Reset asserted mid-sequence (init, refresh or access) aborts it immediately and returns all outputs to reset values next cycle. The init sequence restarts from INIT_WAIT.

## Test plan
Bench parameters for all scenarios: `T_INIT`=10, `T_RP`=2, `T_RFC`=7, `T_MRD`=2, `INIT_REFRESHES`=2, `REF_INTERVAL`=50, `MAX_DEBT`=3. Cycle 0 is the first cycle with reset low.

- Init sequence -> NOP on cycles 0–9; PRECHARGE ALL (addr 0x400) at 10; AUTO REFRESH at 12 and 19; LOAD MODE with addr 0x030 at 26; `init_done`=1 at 28; `acc_gnt`=0 throughout.
- Idle refresh, no requests -> tick at 78 sets `ref_pending`=1; PRECHARGE at 79; AUTO REFRESH at 81 with `ref_pending`→0; IDLE at 88.
- Access and refresh debt: `acc_req` high from 30 to 200 -> `acc_gnt` spans 31–200; `ref_pending` reaches 3 at cycle 178; after release, three back-to-back refreshes complete before any re-grant; `ref_overflow` stays 0.
- Debt overflow: hold `acc_req` high until 250 -> fourth tick at 228 sets `ref_overflow`=1; `ref_pending` stays 3; the flag stays set after the debt drains.
- Simultaneous tick and decrement: align a tick with an AUTO REFRESH issue cycle -> `ref_pending` is unchanged.
- Reset mid-refresh: reset asserted during REF_AR wait -> next cycle all outputs are at reset values; after release, the full init sequence replays with the same cycle numbers as the first scenario.
